// File: rtl/pipe_mem_pkg.sv
// Shared types and defaults for the pipeline memory-port arbiter.
package pipe_mem_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Grant selection between fetch and data requests. Data wins by default;
// a saturating streak of contended data grants forces one fetch grant.
module arb_starve_ctr
    import pipe_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_dm
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak;
    logic          starved;

    assign starved = (streak == LIMIT);

    // Grant select: data first unless fetch has been starved long enough.
    always_comb begin
        grant_valid = if_req | dm_req;
        grant_dm    = dm_req & ~(if_req & starved);
    end

    // Streak of data grants taken while fetch was also waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (grant_en && grant_valid) begin
            if (grant_dm && if_req) begin
                if (!starved) begin
                    streak <= streak + SW'(1);
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one variable-latency memory port between the fetch and memory
// stages: one transaction at a time, registered ack/rdata per stage,
// combinational stalls and a sticky watchdog timeout.
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    owner_t        owner;
    logic [TW-1:0] tcnt;

    logic grant_valid;
    logic grant_dm;
    logic do_grant;
    logic do_done;
    logic timeout_hit;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .dm_req     (dm_req),
        .grant_en   (state == IDLE),
        .grant_valid(grant_valid),
        .grant_dm   (grant_dm)
    );

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = BUSY;
            BUSY:    if (mem_ready || timeout_hit) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded strobes; timeout counts the current BUSY cycle, so it fires
    // on the TIMEOUT-th cycle without mem_ready (mem_ready takes precedence).
    always_comb begin
        do_grant    = (state == IDLE) && grant_valid;
        do_done     = (state == BUSY) && mem_ready;
        timeout_hit = (state == BUSY) && !mem_ready && (tcnt == TLAST);
    end

    // Transaction latch, memory-side outputs, watchdog, completion to owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= OWN_IF;
            tcnt      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (do_grant) begin
                owner     <= grant_dm ? OWN_DM : OWN_IF;
                tcnt      <= '0;
                mem_req   <= 1'b1;
                mem_we    <= grant_dm & dm_we;
                mem_addr  <= grant_dm ? dm_addr : if_addr;
                mem_wdata <= grant_dm ? dm_wdata : '0;
            end else if (do_done || timeout_hit) begin
                mem_req <= 1'b0;
                if (timeout_hit) begin
                    err <= 1'b1;
                end
                if (owner == OWN_DM) begin
                    dm_ack   <= 1'b1;
                    dm_rdata <= (do_done && !mem_we) ? mem_rdata : '0;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= do_done ? mem_rdata : '0;
                end
            end else if (state == BUSY) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: directed scenarios plus an
// ack scoreboard that matches every completion against queued expectations.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        err;

    typedef struct {
        logic        dm;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [1:0]  mon_req;
    logic [31:0] mon_d;
    int pass_cnt = 0;
    int total_cnt = 0;

    pipe_mem_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic dm, input logic [31:0] d);
        exp_t e;
        e.dm = dm;
        e.rdata = d;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (if_ack === 1'b1 || dm_ack === 1'b1) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_ack: got if_ack=%b dm_ack=%b, required no ack", if_ack, dm_ack);
            end else begin
                mon_e = sb.pop_front();
                mon_req = mon_e.dm ? 2'b01 : 2'b10;
                mon_d = mon_e.dm ? dm_rdata : if_rdata;
                if ({if_ack, dm_ack} !== mon_req || mon_d !== mon_e.rdata)
                    $display("FAIL sb_ack: got acks=%b rdata=%h, required acks=%b rdata=%h",
                             {if_ack, dm_ack}, mon_d, mon_req, mon_e.rdata);
                else pass_cnt++;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({mem_req, mem_we, if_ack, dm_ack, err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, required 00000", {mem_req, mem_we, if_ack, dm_ack, err});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata} !== 64'h0)
            $display("FAIL reset_mem_bus: got %h, required 0", {mem_addr, mem_wdata});
        else pass_cnt++;
        total_cnt++;
        if ({if_rdata, dm_rdata} !== 64'h0)
            $display("FAIL reset_rdata: got %h, required 0", {if_rdata, dm_rdata});
        else pass_cnt++;
        rst = 1'b1;
        tick;
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL reset_idle: got mem_req=%b, required 0", mem_req);
        else pass_cnt++;
    endtask

    task automatic test_single_fetch;
        if_req = 1'b1;
        if_addr = 32'h40;
        sb.push_back(mk(1'b0, 32'h1234_5678));
        #1;
        total_cnt++;
        if ({if_stall, mem_req} !== 2'b10)
            $display("FAIL fetch_c0: got stall,mem_req=%b, required 10", {if_stall, mem_req});
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({mem_req, mem_we, if_stall} !== 3'b101 || mem_addr !== 32'h40)
            $display("FAIL fetch_c1: got req,we,stall=%b addr=%h, required 101 addr=00000040",
                     {mem_req, mem_we, if_stall}, mem_addr);
        else pass_cnt++;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick;
        mem_ready = 1'b0;
        total_cnt++;
        if ({if_ack, if_stall, mem_req} !== 3'b100 || if_rdata !== 32'h1234_5678)
            $display("FAIL fetch_c2: got ack,stall,req=%b rdata=%h, required 100 rdata=12345678",
                     {if_ack, if_stall, mem_req}, if_rdata);
        else pass_cnt++;
        if_req = 1'b0;
        tick;
        total_cnt++;
        if (if_ack !== 1'b0) $display("FAIL fetch_ack_pulse: got if_ack=%b, required 0", if_ack);
        else pass_cnt++;
    endtask

    task automatic test_contention;
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hAA;
        sb.push_back(mk(1'b1, 32'h0));
        tick;
        total_cnt++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h100 || mem_wdata !== 32'hAA)
            $display("FAIL contend_dm_grant: got req,we=%b addr=%h wdata=%h, required 11 addr=00000100 wdata=000000aa",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        else pass_cnt++;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick;
        mem_ready = 1'b0;
        total_cnt++;
        if ({dm_ack, if_ack} !== 2'b10 || dm_rdata !== 32'h0)
            $display("FAIL contend_dm_ack: got acks=%b dm_rdata=%h, required 10 dm_rdata=0",
                     {dm_ack, if_ack}, dm_rdata);
        else pass_cnt++;
        dm_req = 1'b0; dm_we = 1'b0;
        sb.push_back(mk(1'b0, 32'h5555_0000));
        tick;
        tick;
        total_cnt++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h80 || mem_wdata !== 32'h0)
            $display("FAIL contend_if_grant: got req,we=%b addr=%h wdata=%h, required 10 addr=00000080 wdata=0",
                     {mem_req, mem_we}, mem_addr, mem_wdata);
        else pass_cnt++;
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_0000;
        tick;
        mem_ready = 1'b0;
        if_req = 1'b0;
        tick;
    endtask

    task automatic test_starvation;
        logic exp_dm [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int g = 0;
        logic [31:0] d;
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int c = 0; c < 40 && g < 6; c++) begin
            tick;
            mem_ready = 1'b0;
            if (mem_req === 1'b1) begin
                d = 32'hA000_0000 + 32'(g);
                total_cnt++;
                if ((mem_addr == 32'h300) !== exp_dm[g])
                    $display("FAIL starve_order[%0d]: got addr=%h, required dm=%b", g, mem_addr, exp_dm[g]);
                else pass_cnt++;
                sb.push_back(mk(exp_dm[g], d));
                mem_ready = 1'b1;
                mem_rdata = d;
                g++;
                if (g == 6) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        tick;
        mem_ready = 1'b0;
        repeat (2) tick;
        total_cnt++;
        if (g != 6) $display("FAIL starve_grants: got %0d grants, required 6", g);
        else pass_cnt++;
    endtask

    task automatic test_ready_at_timeout;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h180;
        sb.push_back(mk(1'b1, 32'hCAFE_F00D));
        for (int c = 1; c <= 15; c++) begin
            tick;
            if (c == 15) begin
                total_cnt++;
                if (mem_req !== 1'b1) $display("FAIL coincide_busy15: got mem_req=%b, required 1", mem_req);
                else pass_cnt++;
                mem_ready = 1'b1;
                mem_rdata = 32'hCAFE_F00D;
            end
        end
        tick;
        mem_ready = 1'b0;
        total_cnt++;
        if ({dm_ack, err} !== 2'b10 || dm_rdata !== 32'hCAFE_F00D)
            $display("FAIL coincide_ack: got ack,err=%b rdata=%h, required 10 rdata=cafef00d",
                     {dm_ack, err}, dm_rdata);
        else pass_cnt++;
        dm_req = 1'b0;
        tick;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick;
        mem_ready = 1'b0;
        tick;
        total_cnt++;
        if ({if_ack, dm_ack, mem_req, err} !== 4'b0 || dm_rdata !== 32'hCAFE_F00D)
            $display("FAIL stray_ready: got acks,req,err=%b dm_rdata=%h, required 0000 dm_rdata=cafef00d",
                     {if_ack, dm_ack, mem_req, err}, dm_rdata);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        int req_cycles = 0;
        logic seen = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1C0;
        mem_rdata = 32'hFFFF_FFFF;
        sb.push_back(mk(1'b1, 32'h0));
        for (int c = 1; c <= 30 && !seen; c++) begin
            tick;
            if (mem_req === 1'b1) req_cycles++;
            if (dm_ack === 1'b1) begin
                seen = 1'b1;
                total_cnt++;
                if (err !== 1'b1 || dm_rdata !== 32'h0)
                    $display("FAIL timeout_ack: got err=%b rdata=%h, required err=1 rdata=0", err, dm_rdata);
                else pass_cnt++;
            end
        end
        dm_req = 1'b0;
        total_cnt++;
        if (!seen || req_cycles != 15)
            $display("FAIL timeout_len: got ack_seen=%b mem_req_cycles=%0d, required 1 and 15", seen, req_cycles);
        else pass_cnt++;
        repeat (5) tick;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL timeout_sticky: got err=%b, required 1", err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_busy;
        logic ack_seen = 1'b0;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h240; dm_wdata = 32'h77;
        tick;
        total_cnt++;
        if (mem_req !== 1'b1) $display("FAIL rstbusy_grant: got mem_req=%b, required 1", mem_req);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({mem_req, mem_we, if_ack, dm_ack, err} !== 5'b0 || {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0)
            $display("FAIL rstbusy_async: got ctrl=%b bus=%h, required all 0",
                     {mem_req, mem_we, if_ack, dm_ack, err}, {mem_addr, mem_wdata, if_rdata, dm_rdata});
        else pass_cnt++;
        dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            mem_ready = (c == 1);
            if (if_ack === 1'b1 || dm_ack === 1'b1 || mem_req === 1'b1) ack_seen = 1'b1;
        end
        mem_ready = 1'b0;
        total_cnt++;
        if (ack_seen !== 1'b0) $display("FAIL rstbusy_no_ack: got activity=%b, required 0", ack_seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_contention;
        test_starvation;
        test_ready_at_timeout;
        test_timeout;
        test_reset_mid_busy;
        repeat (2) tick;
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
